sync_debounce_bank: RTL and testbench
=====================================

# sync_debounce_bank

Multi-channel input conditioner: generalises the single-bit synchronizer to `CHANNELS` independent asynchronous inputs. Each channel gets a parametrised flip-flop synchronizer, a per-channel debounce/glitch filter with runtime bypass, and registered rise/fall edge ticks. It sits at the chip boundary between raw pins (buttons, external strobes, foreign-clock flags) and `clk`-domain logic, which consumes only `sync_out` and the tick outputs.

## Interface
- `CHANNELS`, 4: number of independent channels; must be ≥ 1.
- `SYNC_STAGES`, 2: synchronizer flip-flops per channel; must be ≥ 2.
- `DEBOUNCE_CYCLES`, 4: consecutive `clk` cycles a synchronized change must persist before acceptance; must be ≥ 1.
- `RESET_VALUE`, {CHANNELS{1'b0}}: per-channel value of every synchronizer stage and `sync_out` after reset.

- `clk`  in  1  sole clock; everything is on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `async_in`  in  CHANNELS  asynchronous inputs; no timing relation to `clk`.
- `debounce_en`  in  1  1 = filter active; 0 = bypass (synchronous to `clk`).
- `sync_out`  out  CHANNELS  synchronized, filtered level per channel.
- `rise_edge_tick`  out  CHANNELS  1-cycle pulse when `sync_out[i]` goes 0→1.
- `fall_edge_tick`  out  CHANNELS  1-cycle pulse when `sync_out[i]` goes 1→0.
- `any_edge_tick`  out  1  OR of all rise and fall ticks.

## Operation
- Per channel i: chain `s[0..SYNC_STAGES-1]`; `s[0]` samples `async_in[i]`; `raw = s[SYNC_STAGES-1]`. No logic between stages.
- Filter state: `filt` (drives `sync_out[i]`) and counter `cnt`, width `$clog2(DEBOUNCE_CYCLES)` (minimum 1 bit).
- `debounce_en = 1`:
  - `raw == filt`: `cnt <= 0`.
  - `raw != filt` and `cnt == DEBOUNCE_CYCLES-1`: `filt <= raw`, `cnt <= 0`, matching tick register set.
  - Otherwise: `cnt <= cnt + 1`.
- `debounce_en = 0`: `filt <= raw` every edge, `cnt <= 0`, ticks still generated on change. Behaviour is identical to `DEBOUNCE_CYCLES = 1`.
- Ticks are registered: `rise_edge_tick[i] <= ~filt & next_filt` and `fall_edge_tick[i] <= filt & ~next_filt`. The tick updates on the same edge as `sync_out`.
- `any_edge_tick` is a combinational OR of the tick registers.
- Channels are fully independent. Simultaneous changes on several channels each produce their own ticks in the same cycle.
- Reset: all `s` stages and `filt` are loaded with `RESET_VALUE`; `cnt`, ticks and `any_edge_tick` are 0. No tick is generated on the reset cycle or on the first cycle after reset, whatever the value of `async_in`.
- Reset asserted mid-count discards the partial count.
- `debounce_en` falling mid-count clears `cnt`. `debounce_en` rising starts counting from 0.

## Timing
- Let edge k be the first edge at which `s[0]` captures a new level that then stays stable.
- `raw` changes at edge k+SYNC_STAGES-1.
- Filter on: `sync_out` and the tick change at edge k+SYNC_STAGES+DEBOUNCE_CYCLES-1 (k+5 for the defaults).
- Bypass: `sync_out` and the tick change at edge k+SYNC_STAGES (k+2 for the defaults).
- A `raw` excursion lasting fewer than DEBOUNCE_CYCLES cycles is rejected: no `sync_out` change, no tick.
- Ticks are high for exactly one cycle. The minimum spacing between opposite ticks on one channel is DEBOUNCE_CYCLES cycles (1 in bypass).
- Metastability is confined to `s[0]`. The MTBF budget is met by choosing SYNC_STAGES.

## Structure
- Shared package `sync_pkg`: a `cnt_width(DEBOUNCE_CYCLES)` function (returns ≥ 1) and a parameter-legality check macro used by all synchronizer-family blocks.
- Sub-module `sync_debounce_channel`: one channel (chain, filter, tick registers). Instantiated CHANNELS times in a generate loop.
- The top level does only generation and the `any_edge_tick` reduction.

## Test plan
Setup: CHANNELS=4, SYNC_STAGES=2, DEBOUNCE_CYCLES=4, `clk` 10 ns; stimulus driven from an unrelated 17 ns clock.
- Hold `rst=1` with `async_in=4'hF`, then release with `async_in=4'h0` -> `sync_out=4'h0`; all ticks 0 throughout and for 10 cycles after release.
- Raise `async_in[0]`, captured at edge k, and hold -> `sync_out[0]=1` and `rise_edge_tick[0]=1` for one cycle at edge k+5; `any_edge_tick=1` that cycle; channels 1–3 unchanged.
- Channel 1 `raw` high for 3 cycles -> no change, no tick. The same pulse held for 4 cycles -> accepted, followed later by a fall tick.
- `debounce_en=0`, channel 2 single-cycle pulse captured at edge k -> `sync_out[2]` high for one cycle at edge k+2; rise tick at k+2, fall tick at k+3.
- Channel 0 rising and channel 3 falling captured on the same edge -> `rise_edge_tick=4'b0001` and `fall_edge_tick=4'b1000` in the same cycle; `any_edge_tick` high for one cycle.
- `rst` pulsed for one cycle while channel 1 `cnt==2` -> `cnt` cleared, `sync_out` = RESET_VALUE, no tick. Counting restarts: a full 4 cycles is required after the reset ends.

Source files
------------

// File: rtl/sync_pkg.sv
// Shared definitions for the synchronizer family: debounce counter sizing
// and an elaboration-time parameter legality check.
`timescale 1ns/1ps
`ifndef SYNC_PKG_SV
`define SYNC_PKG_SV

package sync_pkg;

    function automatic int cnt_width(input int cycles);
        if (cycles <= 1) begin
            return 1;
        end else begin
            return $clog2(cycles);
        end
    endfunction

endpackage

// Elaborates an error when cond is false; label names the generate block.
`define SYNC_PARAM_CHECK(label, cond, msg) \
    if (!(cond)) begin : label \
        $error(msg); \
    end

`endif

// File: rtl/sync_debounce_channel.sv
// One input channel: flip-flop synchronizer, debounce filter with runtime
// bypass, and registered rise/fall ticks aligned with the filtered level.
`timescale 1ns/1ps
module sync_debounce_channel
    import sync_pkg::*;
#(
    parameter int   SYNC_STAGES     = 2,
    parameter int   DEBOUNCE_CYCLES = 4,
    parameter logic RESET_VALUE     = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    input  logic debounce_en,
    output logic sync_out,
    output logic rise_edge_tick,
    output logic fall_edge_tick
);

    `SYNC_PARAM_CHECK(g_bad_params, (SYNC_STAGES >= 2) && (DEBOUNCE_CYCLES >= 1),
                      "sync_debounce_channel: need SYNC_STAGES >= 2 and DEBOUNCE_CYCLES >= 1")

    localparam int            CW       = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_r;
    logic                   raw_s;
    logic                   filt_r;
    logic [CW-1:0]          cnt_r;
    logic                   next_filt_s;
    logic [CW-1:0]          next_cnt_s;
    logic                   rise_r;
    logic                   fall_r;

    assign raw_s = sync_r[SYNC_STAGES-1];

    // Synchronizer chain; s[0] is the only flop that may go metastable.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_r <= {SYNC_STAGES{RESET_VALUE}};
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], async_in};
        end
    end

    // Filter decision: accept raw only after it has disagreed long enough.
    always_comb begin
        next_filt_s = filt_r;
        next_cnt_s  = {CW{1'b0}};
        if (!debounce_en) begin
            next_filt_s = raw_s;
        end else if (raw_s == filt_r) begin
            next_cnt_s = {CW{1'b0}};
        end else if (cnt_r == CNT_LAST) begin
            next_filt_s = raw_s;
        end else begin
            next_cnt_s = cnt_r + CW'(1);
        end
    end

    // Filter state and edge ticks update on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            filt_r <= RESET_VALUE;
            cnt_r  <= {CW{1'b0}};
            rise_r <= 1'b0;
            fall_r <= 1'b0;
        end else begin
            filt_r <= next_filt_s;
            cnt_r  <= next_cnt_s;
            rise_r <= ~filt_r & next_filt_s;
            fall_r <= filt_r & ~next_filt_s;
        end
    end

    assign sync_out       = filt_r;
    assign rise_edge_tick = rise_r;
    assign fall_edge_tick = fall_r;

endmodule

// File: rtl/sync_debounce_bank.sv
// Bank of independent synchronize/debounce channels with a combined
// any-edge indication.
`timescale 1ns/1ps
module sync_debounce_bank
    import sync_pkg::*;
#(
    parameter int                  CHANNELS        = 4,
    parameter int                  SYNC_STAGES     = 2,
    parameter int                  DEBOUNCE_CYCLES = 4,
    parameter logic [CHANNELS-1:0] RESET_VALUE     = {CHANNELS{1'b0}}
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CHANNELS-1:0] async_in,
    input  logic                debounce_en,
    output logic [CHANNELS-1:0] sync_out,
    output logic [CHANNELS-1:0] rise_edge_tick,
    output logic [CHANNELS-1:0] fall_edge_tick,
    output logic                any_edge_tick
);

    `SYNC_PARAM_CHECK(g_bad_channels, CHANNELS >= 1,
                      "sync_debounce_bank: need CHANNELS >= 1")

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        sync_debounce_channel #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .RESET_VALUE     (RESET_VALUE[i])
        ) u_channel (
            .clk            (clk),
            .rst            (rst),
            .async_in       (async_in[i]),
            .debounce_en    (debounce_en),
            .sync_out       (sync_out[i]),
            .rise_edge_tick (rise_edge_tick[i]),
            .fall_edge_tick (fall_edge_tick[i])
        );
    end

    assign any_edge_tick = |{rise_edge_tick, fall_edge_tick};

endmodule

// File: tb/tb_sync_debounce_bank.sv
// Self-checking bench for sync_debounce_bank: reset/rise vector table,
// hand-written corner sequences, then free-running random inputs on an
// unrelated 17 ns clock compared against an edge-level reference model.
`timescale 1ns/1ps
module tb_sync_debounce_bank;

    localparam int         CH = 4;
    localparam int         SS = 2;
    localparam int         DB = 4;
    localparam logic [3:0] RV = 4'h0;

    logic          clk = 1'b0;
    logic          rst;
    logic          debounce_en;
    logic [CH-1:0] hand_ain;
    logic [CH-1:0] rand_ain;
    logic          rand_on;
    logic [CH-1:0] async_in;
    logic [CH-1:0] sync_out;
    logic [CH-1:0] rise_edge_tick;
    logic [CH-1:0] fall_edge_tick;
    logic          any_edge_tick;

    int checks   = 0;
    int failures = 0;

    assign async_in = rand_on ? rand_ain : hand_ain;

    sync_debounce_bank #(
        .CHANNELS        (CH),
        .SYNC_STAGES     (SS),
        .DEBOUNCE_CYCLES (DB),
        .RESET_VALUE     (RV)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .async_in       (async_in),
        .debounce_en    (debounce_en),
        .sync_out       (sync_out),
        .rise_edge_tick (rise_edge_tick),
        .fall_edge_tick (fall_edge_tick),
        .any_edge_tick  (any_edge_tick)
    );

    always #5 clk = ~clk;

    // Reference model: the filter sees the input sampled SS edges earlier and
    // flips once that view has disagreed with it on DB consecutive edges
    // (one edge in bypass).
    logic [CH-1:0] m_q[$];
    logic [CH-1:0] m_filt;
    logic [CH-1:0] m_rise;
    logic [CH-1:0] m_fall;
    int            m_run[CH];

    task automatic model_edge();
        logic [CH-1:0] fin;
        logic [CH-1:0] old;
        int            need;
        if (rst) begin
            m_q.delete();
            repeat (SS) m_q.push_back(RV);
            m_filt = RV;
            m_rise = '0;
            m_fall = '0;
            for (int c = 0; c < CH; c++) m_run[c] = 0;
        end else begin
            fin = m_q.pop_front();
            m_q.push_back(async_in);
            need = debounce_en ? DB : 1;
            old  = m_filt;
            for (int c = 0; c < CH; c++) begin
                m_run[c] = (fin[c] != m_filt[c]) ? m_run[c] + 1 : 0;
                if (m_run[c] >= need) begin
                    m_filt[c] = fin[c];
                    m_run[c]  = 0;
                end
            end
            m_rise = ~old & m_filt;
            m_fall = old & ~m_filt;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic chk_out(input string name, input logic [3:0] so, input logic [3:0] r,
                           input logic [3:0] f);
        chk({name, ".sync_out"}, 32'(sync_out), 32'(so));
        chk({name, ".rise"},     32'(rise_edge_tick), 32'(r));
        chk({name, ".fall"},     32'(fall_edge_tick), 32'(f));
        chk({name, ".any"},      32'(any_edge_tick), 32'((|r) | (|f)));
    endtask

    // Drive a new level and expect the filtered level to follow after lat edges.
    task automatic run_change(input string name, input logic [3:0] from, input logic [3:0] to,
                              input int lat, input int n);
        hand_ain = to;
        for (int i = 0; i < n; i++) begin
            step();
            chk_out(name, (i < lat) ? from : to,
                    (i == lat) ? (~from & to) : 4'h0,
                    (i == lat) ? (from & ~to) : 4'h0);
        end
    endtask

    // Unrelated-clock stimulus, phase-offset so it never lands on a clk edge.
    initial begin
        rand_ain = 4'h0;
        #0.3;
        forever begin
            #17;
            if (rand_on) begin
                for (int b = 0; b < CH; b++) begin
                    if ($urandom_range(5) == 0) rand_ain[b] = ~rand_ain[b];
                end
            end
        end
    end

    typedef struct {
        logic       rst;
        logic [3:0] ain;
        logic [3:0] so;
        logic [3:0] rise;
    } vec_t;

    vec_t tbl[19];

    initial begin
        rst         = 1'b1;
        debounce_en = 1'b1;
        hand_ain    = 4'hF;
        rand_on     = 1'b0;

        // Reset held with all inputs high, ten quiet cycles, then channel 0 rises.
        for (int i = 0; i < 19; i++) begin
            tbl[i].rst  = (i < 2) ? 1'b1 : 1'b0;
            tbl[i].ain  = (i < 2) ? 4'hF : ((i < 12) ? 4'h0 : 4'h1);
            tbl[i].so   = (i < 17) ? 4'h0 : 4'h1;
            tbl[i].rise = (i == 17) ? 4'h1 : 4'h0;
        end
        for (int i = 0; i < 19; i++) begin
            rst      = tbl[i].rst;
            hand_ain = tbl[i].ain;
            step();
            chk_out($sformatf("table[%0d]", i), tbl[i].so, tbl[i].rise, 4'h0);
        end

        // Channel 1 high for 3 captures is rejected.
        for (int i = 0; i < 8; i++) begin
            hand_ain = (i < 3) ? 4'h3 : 4'h1;
            step();
            chk_out("glitch3", 4'h1, 4'h0, 4'h0);
        end

        // Channel 1 high for 4 captures is accepted, then falls later.
        for (int i = 0; i < 12; i++) begin
            hand_ain = (i < 4) ? 4'h3 : 4'h1;
            step();
            chk_out("pulse4", ((i >= 5) && (i <= 8)) ? 4'h3 : 4'h1,
                    (i == 5) ? 4'h2 : 4'h0, (i == 9) ? 4'h2 : 4'h0);
        end

        // Bypass: one-capture pulse on channel 2 passes through for one cycle.
        debounce_en = 1'b0;
        for (int i = 0; i < 6; i++) begin
            hand_ain = (i == 0) ? 4'h5 : 4'h1;
            step();
            chk_out("bypass", (i == 2) ? 4'h5 : 4'h1,
                    (i == 2) ? 4'h4 : 4'h0, (i == 3) ? 4'h4 : 4'h0);
        end
        debounce_en = 1'b1;

        // Simultaneous opposite changes on channels 0 and 3, both directions.
        run_change("swap_a", 4'h1, 4'h8, 5, 8);
        run_change("swap_b", 4'h8, 4'h1, 5, 8);

        // Reset pulsed while channel 1 is two counts in; the count restarts.
        hand_ain = 4'h3;
        for (int i = 0; i < 4; i++) begin
            step();
            chk_out("pre_rst", 4'h1, 4'h0, 4'h0);
        end
        rst = 1'b1;
        step();
        chk_out("mid_rst", RV, 4'h0, 4'h0);
        rst = 1'b0;
        for (int i = 0; i < 7; i++) begin
            step();
            chk_out("post_rst", (i >= 5) ? 4'h3 : 4'h0, (i == 5) ? 4'h3 : 4'h0, 4'h0);
        end

        // Random asynchronous inputs, bypass toggling and occasional resets.
        rand_on = 1'b1;
        for (int i = 0; i < 1500; i++) begin
            step();
            chk("random", {19'h0, any_edge_tick, fall_edge_tick, rise_edge_tick, sync_out},
                {19'h0, (|m_rise) | (|m_fall), m_fall, m_rise, m_filt});
            if ($urandom_range(39) == 0) debounce_en = ~debounce_en;
            rst = ($urandom_range(149) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
